page_switch_ctrl: RTL and testbench
===================================

Name: page_switch_ctrl

Overview:
Synchronous page-select controller for the page-level VGA design.
- Takes the 16-bit matrix-key vector from mat_key, and optionally the PS2 arrow keys.
- Drives the page index that selects one of the page pixel_data sources ahead of VGA.
- Synchronizes and debounces the buttons, turns presses into next/prev requests, and applies page changes only at a frame boundary so pages never tear mid-frame.

Parameters:
- NUM_PAGES, 4: number of selectable pages; any value 2..2**PAGE_W.
- PAGE_W, 2: width of the page index.
- BTN_W, 16: width of the matrix-key vector.
- DEBOUNCE_CYCLES, 250000: vga_clk cycles between debounce samples (10 ms at 25 MHz); minimum 2.
- CNT_W, 18: prescaler width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.
- NEXT_BTN, 0: btns bit index that means "next page".
- PREV_BTN, 1: btns bit index that means "previous page".

Ports:
- vga_clk  in  1  sole clock.
- vga_rst  in  1  reset; synchronous, active-high.
- btns  in  BTN_W  raw matrix-key levels; 1 = pressed; asynchronous to vga_clk.
- keys  in  5  PS2 decoded levels {space,down,right,left,up}; used only under the optional feature.
- x_pos  in  10  current VGA column.
- y_pos  in  10  current VGA row.
- page_status  out  PAGE_W  committed page index.
- page_changed  out  1  one-cycle pulse on the cycle page_status updates.
- pending  out  1  high while a page change waits for a frame boundary.
- btns_clean  out  BTN_W  debounced button levels.
- btn_rise  out  BTN_W  one-cycle pulse per debounced press.

Behaviour:
- Reset: on vga_rst sampled high at a vga_clk edge:
  - page_status, page_changed, pending, btns_clean, btn_rise, prescaler, sample histories and synchronizer flops all go to 0.
  - State goes to IDLE.
  - Reset mid-PENDING discards the target.
  - A button held through reset produces a rise after debounce.
- Synchronizer: 2 flops per btns bit.
- Prescaler:
  - Counts 0..DEBOUNCE_CYCLES-1, then wraps.
  - tick is high for the one cycle in which the count equals DEBOUNCE_CYCLES-1.
- Sampling:
  - On each tick, a 3-deep history per bit shifts in the synchronized level.
  - btns_clean[i] updates on the cycle after a tick, and only if all 3 history entries agree; otherwise it holds.
- Edges: btn_rise[i] = btns_clean[i] rising, registered; exactly 1 cycle wide per press.
- Latency: a stable press reaches btns_clean 2 sync cycles plus 3 to 4 ticks after it appears. A single sample (≤1 tick wide) is rejected.
- Requests:
  - nxt = btn_rise[NEXT_BTN]; prv = btn_rise[PREV_BTN].
  - nxt and prv in the same cycle cancel; no action.
- Arithmetic:
  - inc(p) = (p == NUM_PAGES-1) ? 0 : p+1.
  - dec(p) = (p == 0) ? NUM_PAGES-1 : p-1.
  - Explicit wrap; no reliance on power-of-2 overflow.
- Frame boundary:
  - fb is high for 1 cycle when (x_pos,y_pos) == (0,0) and was not (0,0) in the previous cycle.
  - Registered compare, so fb trails entry to (0,0) by 1 cycle.
- FSM:
  - IDLE:
    - nxt: target = inc(page_status), go to PENDING.
    - prv: target = dec(page_status), go to PENDING.
  - PENDING:
    - nxt/prv adjust the target via inc/dec of target (accumulate).
    - On fb: page_status <= target; page_changed = 1 if target != page_status; go to IDLE.
    - If fb and a request fall in the same cycle, the commit uses the pre-request target; the request is then processed in IDLE on the next request edge. Requests coinciding with fb are dropped.
  - A request arriving in IDLE on the same cycle as fb does not commit; it waits for the next fb.
- pending = (state == PENDING).

Optional Feature:
- Macro PAGE_SWITCH_PS2_NAV_EN.
- Defined:
  - keys pass through a 2-flop synchronizer and a registered rise detect; no debounce, since PS2 output is already clean.
  - Rise of keys[2] (right) ORs into nxt; rise of keys[1] (left) ORs into prv.
  - The cancel rule applies to the combined requests.
- Undefined: keys is ignored; no logic is generated for it.

Decomposition:
- Package page_pkg:
  - NUM_PAGES and PAGE_W defaults.
  - Page index constants: PAGE_PS2_DEBUG=0, PAGE_TEST=1, PAGE_DEBUG=2, PAGE_MAIN=3.
  - FSM state typedef (IDLE, PENDING).
- Sub-module btn_debounce (params BTN_W, DEBOUNCE_CYCLES, CNT_W) contains the synchronizer, prescaler, 3-sample history, btns_clean and btn_rise.
- page_switch_ctrl instantiates btn_debounce and adds the FSM and frame-boundary logic.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, frame emulated as x/y counters of 8x4.
- Reset: hold vga_rst 3 cycles with btns=16'h0001 -> all outputs 0 during reset; btn_rise[0] pulses once 2 sync cycles + 3–4 ticks after release.
- Glitch: btns[0] high for 3 cycles -> btns_clean stays 0, no btn_rise, pending stays 0.
- Next at frame boundary: clean press of btns[0] mid-frame -> pending=1; at next fb page_status 0->1, page_changed one cycle, pending=0; no change before fb.
- Wrap: page_status=3, press NEXT -> 0 after fb. Page 0, press PREV -> 3. NUM_PAGES=3 build: 2 -> 0 via NEXT.
- Accumulate/cancel:
  - NEXT twice before fb from page 1 -> page 3 in one commit, one page_changed.
  - NEXT then PREV -> fb commits no change, page_changed stays 0.
  - NEXT and PREV rising in the same cycle -> pending stays 0.
- PS2 (PAGE_SWITCH_PS2_NAV_EN defined): keys[2] pulse -> page +1 at fb. Macro undefined: same stimulus -> no change.

Source files
------------

// File: rtl/page_pkg.sv
// Shared definitions for the page-select controller: default page count and
// index width, the page index map, and the controller FSM state type.
package page_pkg;

  localparam int DEF_NUM_PAGES = 4;
  localparam int DEF_PAGE_W    = 2;

  // Page index map as wired ahead of the VGA pixel mux.
  localparam logic [DEF_PAGE_W-1:0] PAGE_PS2_DEBUG = 2'd0;
  localparam logic [DEF_PAGE_W-1:0] PAGE_TEST      = 2'd1;
  localparam logic [DEF_PAGE_W-1:0] PAGE_DEBUG     = 2'd2;
  localparam logic [DEF_PAGE_W-1:0] PAGE_MAIN      = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } page_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, shared sample prescaler,
// 3-deep sample history per bit, debounced levels and one-cycle press pulses.
module btn_debounce #(
  parameter int BTN_W           = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic             vga_clk,
  input  logic             vga_rst,
  input  logic [BTN_W-1:0] btns,
  output logic [BTN_W-1:0] btns_clean,
  output logic [BTN_W-1:0] btn_rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [BTN_W-1:0] sync1, sync2;
  logic [BTN_W-1:0] hist0, hist1, hist2;
  logic [BTN_W-1:0] clean_prev;
  logic [BTN_W-1:0] all_high, all_low;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             tick_d;

  assign tick     = (cnt == CNT_MAX);
  assign all_high = hist0 & hist1 & hist2;
  assign all_low  = ~(hist0 | hist1 | hist2);

  // Bring the asynchronous key levels into the vga_clk domain.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btns;
      sync2 <= sync1;
    end
  end

  // Free-running sample prescaler; tick marks the last count before wrap.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      cnt    <= '0;
      tick_d <= 1'b0;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      tick_d <= tick;
    end
  end

  // Shift the synchronized level into the history on every tick.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
    end else if (tick) begin
      hist0 <= sync2;
      hist1 <= hist0;
      hist2 <= hist1;
    end
  end

  // Clean level follows the history only when all three samples agree.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      btns_clean <= '0;
    end else if (tick_d) begin
      btns_clean <= all_high | (btns_clean & ~all_low);
    end
  end

  // Registered rising-edge detect on the clean level.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      clean_prev <= '0;
      btn_rise   <= '0;
    end else begin
      clean_prev <= btns_clean;
      btn_rise   <= btns_clean & ~clean_prev;
    end
  end

endmodule

// File: rtl/page_switch_ctrl.sv
// Page-select controller: turns debounced next/prev presses into a page index
// that only changes at a frame boundary, so a page never tears mid-frame.
// Optional PS2 arrow navigation is enabled by defining PAGE_SWITCH_PS2_NAV_EN.
// The FSM state is visible on the pending output (1 = PENDING, 0 = IDLE).
module page_switch_ctrl
  import page_pkg::*;
#(
  parameter int NUM_PAGES       = DEF_NUM_PAGES,
  parameter int PAGE_W          = DEF_PAGE_W,
  parameter int BTN_W           = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int NEXT_BTN        = 0,
  parameter int PREV_BTN        = 1
) (
  input  logic              vga_clk,
  input  logic              vga_rst,
  input  logic [BTN_W-1:0]  btns,
  input  logic [4:0]        keys,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  output logic [PAGE_W-1:0] page_status,
  output logic              page_changed,
  output logic              pending,
  output logic [BTN_W-1:0]  btns_clean,
  output logic [BTN_W-1:0]  btn_rise
);

  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);

  // Explicit wrap so non-power-of-2 page counts behave.
  function automatic logic [PAGE_W-1:0] inc_page(input logic [PAGE_W-1:0] p);
    return (p == LAST_PAGE) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PAGE_W-1:0] dec_page(input logic [PAGE_W-1:0] p);
    return (p == '0) ? LAST_PAGE : p - 1'b1;
  endfunction

  page_state_e       state, state_nx;
  logic [PAGE_W-1:0] target, target_nx;
  logic [PAGE_W-1:0] page_nx;
  logic              changed_nx;
  logic              origin_q, fb;
  logic              ps2_nxt, ps2_prv;
  logic              raw_nxt, raw_prv;
  logic              req_nxt, req_prv;

  btn_debounce #(
    .BTN_W          (BTN_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .vga_clk   (vga_clk),
    .vga_rst   (vga_rst),
    .btns      (btns),
    .btns_clean(btns_clean),
    .btn_rise  (btn_rise)
  );

`ifdef PAGE_SWITCH_PS2_NAV_EN
  // Only right (bit 2) and left (bit 1) navigate; the rest are not needed here.
  logic [1:0] key_s1, key_s2, key_prev, key_rise;
  logic       unused_keys;
  assign unused_keys = ^{keys[4:3], keys[0]};

  // PS2 levels are already clean: synchronize and edge-detect only.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
      key_rise <= '0;
    end else begin
      key_s1   <= keys[2:1];
      key_s2   <= key_s1;
      key_prev <= key_s2;
      key_rise <= key_s2 & ~key_prev;
    end
  end

  assign ps2_nxt = key_rise[1];
  assign ps2_prv = key_rise[0];
`else
  logic unused_keys;
  assign unused_keys = ^keys;
  assign ps2_nxt     = 1'b0;
  assign ps2_prv     = 1'b0;
`endif

  // Simultaneous next and prev cancel each other.
  assign raw_nxt = btn_rise[NEXT_BTN] | ps2_nxt;
  assign raw_prv = btn_rise[PREV_BTN] | ps2_prv;
  assign req_nxt = raw_nxt & ~raw_prv;
  assign req_prv = raw_prv & ~raw_nxt;

  // Frame boundary: first cycle at (0,0), registered so it trails entry by 1.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      origin_q <= 1'b0;
      fb       <= 1'b0;
    end else begin
      origin_q <= (x_pos == 10'd0) && (y_pos == 10'd0);
      fb       <= (x_pos == 10'd0) && (y_pos == 10'd0) && !origin_q;
    end
  end

  // FSM state, target and committed page registers.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      state        <= IDLE;
      target       <= '0;
      page_status  <= '0;
      page_changed <= 1'b0;
    end else begin
      state        <= state_nx;
      target       <= target_nx;
      page_status  <= page_nx;
      page_changed <= changed_nx;
    end
  end

  // Next state: collect requests into target, commit only on a frame boundary.
  // A request coinciding with fb in PENDING is dropped; in IDLE it waits.
  always_comb begin
    state_nx   = state;
    target_nx  = target;
    page_nx    = page_status;
    changed_nx = 1'b0;
    case (state)
      IDLE: begin
        if (req_nxt) begin
          target_nx = inc_page(page_status);
          state_nx  = PENDING;
        end else if (req_prv) begin
          target_nx = dec_page(page_status);
          state_nx  = PENDING;
        end
      end
      PENDING: begin
        if (fb) begin
          page_nx    = target;
          changed_nx = (target != page_status);
          state_nx   = IDLE;
        end else if (req_nxt) begin
          target_nx = inc_page(target);
        end else if (req_prv) begin
          target_nx = dec_page(target);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pending = (state == PENDING);

endmodule

// File: tb/tb_page_switch_ctrl.sv
// Bench for page_switch_ctrl with a 4-page and a 3-page instance sharing
// stimulus; frame emulated as an 8x4 raster stepped only while running.
module tb_page_switch_ctrl;

  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_PREV   = 3'd1;
  localparam logic [2:0] OP_NN     = 3'd2;
  localparam logic [2:0] OP_NP     = 3'd3;
  localparam logic [2:0] OP_BOTH   = 3'd4;
  localparam logic [2:0] OP_GLITCH = 3'd5;
  localparam logic [2:0] OP_KEY    = 3'd6;
  localparam int         NVEC      = 11;

  typedef struct packed {
    logic [2:0] op;
    logic       exp_pend;
    logic [1:0] exp4;
    logic [1:0] exp3;
    logic [7:0] chg4;
    logic [7:0] chg3;
  } vec_t;

  logic        clk = 1'b0;
  logic        vga_rst;
  logic [15:0] btns;
  logic [4:0]  keys;
  logic [9:0]  x_pos, y_pos;

  logic [1:0]  page4, page3;
  logic        chg4, chg3, pend4, pend3;
  logic [15:0] clean4, clean3, rise4, rise3;

  int total = 0;
  int bad   = 0;
  int rise0_cnt = 0;
  int chg4_cnt  = 0;
  int chg3_cnt  = 0;

  logic [3:0] exp_q[$];
  vec_t       vecs[NVEC];

  // Clock
  always #5 clk = ~clk;

  page_switch_ctrl #(
    .NUM_PAGES(4), .PAGE_W(2), .BTN_W(16), .DEBOUNCE_CYCLES(4), .CNT_W(2),
    .NEXT_BTN(0), .PREV_BTN(1)
  ) dut (
    .vga_clk(clk), .vga_rst(vga_rst), .btns(btns), .keys(keys),
    .x_pos(x_pos), .y_pos(y_pos), .page_status(page4), .page_changed(chg4),
    .pending(pend4), .btns_clean(clean4), .btn_rise(rise4)
  );

  page_switch_ctrl #(
    .NUM_PAGES(3), .PAGE_W(2), .BTN_W(16), .DEBOUNCE_CYCLES(4), .CNT_W(2),
    .NEXT_BTN(0), .PREV_BTN(1)
  ) dut3 (
    .vga_clk(clk), .vga_rst(vga_rst), .btns(btns), .keys(keys),
    .x_pos(x_pos), .y_pos(y_pos), .page_status(page3), .page_changed(chg3),
    .pending(pend3), .btns_clean(clean3), .btn_rise(rise3)
  );

  // Event monitors
  always @(negedge clk) begin
    if (rise4[0] === 1'b1) rise0_cnt++;
    if (chg4 === 1'b1) chg4_cnt++;
    if (chg3 === 1'b1) chg3_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Step the raster for n cycles, then freeze it where it is.
  task automatic run_frame(input int n);
    repeat (n) begin
      @(negedge clk);
      if (x_pos == 10'd7) begin
        x_pos = 10'd0;
        y_pos = (y_pos == 10'd3) ? 10'd0 : y_pos + 10'd1;
      end else begin
        x_pos = x_pos + 10'd1;
      end
    end
  endtask

  task automatic press(input logic [15:0] mask);
    @(negedge clk);
    btns = mask;
    wait_cycles(24);
    btns = 16'h0;
    wait_cycles(24);
  endtask

  task automatic glitch();
    @(negedge clk);
    btns = 16'h0001;
    wait_cycles(3);
    btns = 16'h0;
    wait_cycles(30);
  endtask

  task automatic key_pulse();
    @(negedge clk);
    keys = 5'b00100;
    wait_cycles(3);
    keys = 5'b0;
    wait_cycles(10);
  endtask

  task automatic do_op(input logic [2:0] op);
    case (op)
      OP_NEXT:   press(16'h0001);
      OP_PREV:   press(16'h0002);
      OP_NN:     begin press(16'h0001); press(16'h0001); end
      OP_NP:     begin press(16'h0001); press(16'h0002); end
      OP_BOTH:   press(16'h0003);
      OP_GLITCH: glitch();
      OP_KEY:    key_pulse();
      default:   ;
    endcase
  endtask

  initial begin
    int lat;
    int c4, c3, r0;
    logic [1:0] prev4;
    logic [3:0] exp_pages;

    //                op         pend  p4    p3    chg4 chg3
    vecs[0]  = '{OP_NEXT,   1'b1, 2'd2, 2'd2, 8'd1, 8'd1};
    vecs[1]  = '{OP_NEXT,   1'b1, 2'd3, 2'd0, 8'd1, 8'd1};
    vecs[2]  = '{OP_NEXT,   1'b1, 2'd0, 2'd1, 8'd1, 8'd1};
    vecs[3]  = '{OP_PREV,   1'b1, 2'd3, 2'd0, 8'd1, 8'd1};
    vecs[4]  = '{OP_PREV,   1'b1, 2'd2, 2'd2, 8'd1, 8'd1};
    vecs[5]  = '{OP_NP,     1'b1, 2'd2, 2'd2, 8'd0, 8'd0};
    vecs[6]  = '{OP_BOTH,   1'b0, 2'd2, 2'd2, 8'd0, 8'd0};
    vecs[7]  = '{OP_PREV,   1'b1, 2'd1, 2'd1, 8'd1, 8'd1};
    vecs[8]  = '{OP_NN,     1'b1, 2'd3, 2'd0, 8'd1, 8'd1};
    vecs[9]  = '{OP_GLITCH, 1'b0, 2'd3, 2'd0, 8'd0, 8'd0};
`ifdef PAGE_SWITCH_PS2_NAV_EN
    vecs[10] = '{OP_KEY,    1'b1, 2'd0, 2'd1, 8'd1, 8'd1};
`else
    vecs[10] = '{OP_KEY,    1'b0, 2'd3, 2'd0, 8'd0, 8'd0};
`endif

    // Reset with NEXT held through it.
    vga_rst = 1'b1;
    btns    = 16'h0001;
    keys    = 5'b0;
    x_pos   = 10'd3;
    y_pos   = 10'd1;
    wait_cycles(2);
    check("rst_outputs", {page4, chg4, pend4, clean4, rise4}, 32'h0);
    check("rst_page3", {page3, pend3}, 32'h0);
    wait_cycles(1);
    vga_rst = 1'b0;

    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rise4[0] === 1'b1 && lat < 0) lat = i;
    end
    check("rst_rise_once", rise0_cnt, 1);
    check("rst_rise_lat_ok", (lat >= 10 && lat <= 20), 1);
    check("rst_pending", pend4, 1'b1);
    btns = 16'h0;
    wait_cycles(24);
    check("rst_hold_before_fb", page4, 2'd0);
    c4 = chg4_cnt;
    c3 = chg3_cnt;
    exp_q.push_back({2'd1, 2'd1});
    run_frame(40);
    exp_pages = exp_q.pop_front();
    check("rst_commit_pages", {page4, page3}, exp_pages);
    check("rst_chg4", chg4_cnt - c4, 1);
    check("rst_chg3", chg3_cnt - c3, 1);
    prev4 = 2'd1;

    for (int i = 0; i < NVEC; i++) begin
      r0 = rise0_cnt;
      c4 = chg4_cnt;
      c3 = chg3_cnt;
      exp_q.push_back({vecs[i].exp4, vecs[i].exp3});
      do_op(vecs[i].op);
      check($sformatf("v%0d_pending", i), pend4, vecs[i].exp_pend);
      check($sformatf("v%0d_pending3", i), pend3, vecs[i].exp_pend);
      check($sformatf("v%0d_hold_before_fb", i), page4, prev4);
      check($sformatf("v%0d_no_chg_before_fb", i), chg4_cnt - c4, 0);
      if (vecs[i].op == OP_GLITCH) begin
        check($sformatf("v%0d_glitch_rise", i), rise0_cnt - r0, 0);
        check($sformatf("v%0d_glitch_clean", i), clean4[0], 1'b0);
      end
      run_frame(40);
      exp_pages = exp_q.pop_front();
      check($sformatf("v%0d_pages", i), {page4, page3}, exp_pages);
      check($sformatf("v%0d_chg4", i), chg4_cnt - c4, {24'h0, vecs[i].chg4});
      check($sformatf("v%0d_chg3", i), chg3_cnt - c3, {24'h0, vecs[i].chg3});
      check($sformatf("v%0d_pending_after", i), pend4, 1'b0);
      prev4 = vecs[i].exp4;
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
